// File: rtl/mux_pkg.sv
// Shared helpers for mux_qual_arb: width derivation and the priority encoder
// used by both the fixed-priority and round-robin (MUX_RR_EN) arbiter modes.
package mux_pkg;

  // Widest request vector the priority encoder accepts.
  localparam int unsigned MaxCh = 32;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Width of a channel index.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return clog2_safe(num_ch);
  endfunction

  // Width of a stability counter that must hold 0..stable_cyc.
  function automatic int unsigned cnt_w(input int unsigned stable_cyc);
    return clog2_safe(stable_cyc + 1);
  endfunction

  // Index of the lowest set bit; 0 when nothing is requested.
  function automatic int unsigned prio_enc(input logic [MaxCh-1:0] req);
    int unsigned idx;
    idx = 0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_chan_qual.sv
// One input channel of mux_qual_arb: registers data/enable, counts stable
// cycles, snapshots the data once per enable episode and holds it pending
// until the arbiter grants it.
//   clk_a, arstn : clock, async active-low reset
//   data_i, en_i : raw channel data and enable
//   grant_i      : arbiter takes this channel's snapshot this cycle
//   pend_o       : snapshot waiting for delivery
//   snap_o       : snapshot value
//   ovf_o        : sticky, a pending snapshot was overwritten
module mux_chan_qual
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned STABLE_CYC = 3
) (
  input  logic              clk_a,
  input  logic              arstn,
  input  logic [DATA_W-1:0] data_i,
  input  logic              en_i,
  input  logic              grant_i,
  output logic              pend_o,
  output logic [DATA_W-1:0] snap_o,
  output logic              ovf_o
);

  localparam int unsigned      CNT_W  = cnt_w(STABLE_CYC);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYC);

  logic [DATA_W-1:0] data_q, snap_q, snap_d;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qual_q, qual_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;

  // Counter saturates, so reaching CntMax happens once per stable run;
  // qual_q marks that run and fires the snapshot on the following edge.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_q || (data_i != data_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    qual_d = (cnt_d == CntMax) && (cnt_q != CntMax);
  end

  // A qualification on the same edge as a grant keeps the new value pending
  // and is not an overwrite: the old value is leaving via the grant.
  always_comb begin
    snap_d = snap_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (qual_q) begin
      snap_d = data_q;
      pend_d = 1'b1;
      if (pend_q && !grant_i) ovf_d = 1'b1;
    end else if (grant_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      data_q <= '0;
      en_q   <= 1'b0;
      cnt_q  <= '0;
      qual_q <= 1'b0;
      snap_q <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_i;
      en_q   <= en_i;
      cnt_q  <= cnt_d;
      qual_q <= qual_d;
      snap_q <= snap_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign snap_o = snap_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/mux_qual_arb.sv
// Multi-channel enable-qualified data mux. Each channel is debounced by
// mux_chan_qual; pending snapshots are arbitrated onto one registered output
// with a valid/ready handshake.
// Build option: define MUX_RR_EN for round-robin arbitration (search starts one
// past the last grant); otherwise fixed priority, lowest index wins.
//   clk_a, arstn         : clock, async active-low reset
//   data_in, data_en     : per-channel data (channel i at [i*DATA_W +: DATA_W])
//                          and enable
//   dataout, dout_ch     : delivered snapshot and its source channel
//   dout_valid/ready     : output handshake
//   ovf                  : sticky per-channel overwrite flags
module mux_qual_arb
  import mux_pkg::*;
#(
  parameter  int unsigned DATA_W     = 4,
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned STABLE_CYC = 3,
  localparam int unsigned CH_W       = ch_w(NUM_CH)
) (
  input  logic                     clk_a,
  input  logic                     arstn,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        data_en,
  output logic [DATA_W-1:0]        dataout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [CH_W-1:0]          dout_ch,
  output logic [NUM_CH-1:0]        ovf
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] snap [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    mux_chan_qual #(
      .DATA_W    (DATA_W),
      .STABLE_CYC(STABLE_CYC)
    ) u_chan (
      .clk_a  (clk_a),
      .arstn  (arstn),
      .data_i (data_in[i*DATA_W +: DATA_W]),
      .en_i   (data_en[i]),
      .grant_i(grant[i]),
      .pend_o (pend[i]),
      .snap_o (snap[i]),
      .ovf_o  (ovf[i])
    );
  end

  logic             load, any_pend;
  logic [CH_W-1:0]  sel;
  logic [MaxCh-1:0] req_ext;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic [CH_W-1:0]   dout_ch_q, dout_ch_d;
  logic              dout_valid_q, dout_valid_d;

  // Output register may load when empty or being emptied this edge.
  assign load     = !dout_valid_q || dout_ready;
  assign any_pend = |pend;

`ifdef MUX_RR_EN
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [2*NUM_CH-1:0] pend_dbl;
  int unsigned         rr_sum;

  // Rotate so the search origin is bit 0, encode, then rotate the index back.
  always_comb begin
    pend_dbl = {pend, pend} >> ptr_q;
    req_ext  = '0;
    req_ext[NUM_CH-1:0] = pend_dbl[NUM_CH-1:0];
    rr_sum   = 32'(ptr_q) + prio_enc(req_ext);
    if (rr_sum >= NUM_CH) rr_sum = rr_sum - NUM_CH;
    sel      = CH_W'(rr_sum);
    ptr_d    = ptr_q;
    if (load && any_pend) begin
      ptr_d = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    req_ext = '0;
    req_ext[NUM_CH-1:0] = pend;
    sel     = CH_W'(prio_enc(req_ext));
  end
`endif

  always_comb begin
    grant = '0;
    if (load && any_pend) grant[sel] = 1'b1;
  end

  // With nothing pending at a handshake, valid drops but data/channel hold.
  always_comb begin
    dout_valid_d = dout_valid_q;
    dataout_d    = dataout_q;
    dout_ch_d    = dout_ch_q;
    if (load) begin
      dout_valid_d = any_pend;
      if (any_pend) begin
        dataout_d = snap[sel];
        dout_ch_d = sel;
      end
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      dout_valid_q <= 1'b0;
      dataout_q    <= '0;
      dout_ch_q    <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dataout_q    <= dataout_d;
      dout_ch_q    <= dout_ch_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dataout    = dataout_q;
  assign dout_ch    = dout_ch_q;

endmodule

// File: tb/tb_mux_qual_arb.sv
// Self-checking bench for mux_qual_arb (DATA_W=4, NUM_CH=4, STABLE_CYC=3).
// Directed vector tables, an async-reset sequence, then random stimulus
// against a run-length reference model.
module tb_mux_qual_arb;

  localparam int unsigned DW = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned SC = 3;
`ifdef MUX_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic           clk_a = 1'b0;
  logic           arstn;
  logic [NC*DW-1:0] data_in;
  logic [NC-1:0]  data_en;
  logic [DW-1:0]  dataout;
  logic           dout_valid;
  logic           dout_ready;
  logic [1:0]     dout_ch;
  logic [NC-1:0]  ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_a = ~clk_a;

  mux_qual_arb #(
    .DATA_W    (DW),
    .NUM_CH    (NC),
    .STABLE_CYC(SC)
  ) dut (
    .clk_a     (clk_a),
    .arstn     (arstn),
    .data_in   (data_in),
    .data_en   (data_en),
    .dataout   (dataout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_ch   (dout_ch),
    .ovf       (ovf)
  );

  // Reference model: per channel, the length of the current run of samples
  // with enable high and unchanged data; an event becomes pending one edge
  // after the run first reaches SC.
  int            m_run [NC];
  logic          m_en_prev [NC];
  logic [DW-1:0] m_d_prev [NC];
  logic          m_qual [NC];
  logic [DW-1:0] m_qval [NC];
  logic [DW-1:0] m_snap [NC];
  logic [NC-1:0] m_pend, m_ovf;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_ch;
  int            m_ptr;

  function automatic int pick(input logic [NC-1:0] p, input int start);
    for (int k = 0; k < NC; k++) begin
      if (p[(start + k) % NC]) return (start + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0; m_en_prev[i] = 1'b0; m_d_prev[i] = '0;
      m_qual[i] = 1'b0; m_qval[i] = '0; m_snap[i] = '0;
    end
    m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0;
  endtask

  task automatic model_edge(input logic [NC-1:0] en, input logic [NC*DW-1:0] d,
                            input logic rdy);
    int            g;
    logic [NC-1:0] granted;
    logic [DW-1:0] di;
    granted = '0;
    if (!m_valid || rdy) begin
      g = pick(m_pend, Rr ? m_ptr : 0);
      if (g >= 0) begin
        m_data = m_snap[g]; m_ch = 2'(g); m_valid = 1'b1;
        granted[g] = 1'b1; m_ptr = (g + 1) % NC;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (m_qual[i]) begin
        if (m_pend[i] && !granted[i]) m_ovf[i] = 1'b1;
        m_snap[i] = m_qval[i];
        m_pend[i] = 1'b1;
      end else if (granted[i]) begin
        m_pend[i] = 1'b0;
      end
      di = d[i*DW +: DW];
      if (m_en_prev[i] && di == m_d_prev[i]) m_run[i]++;
      else m_run[i] = 0;
      m_qual[i] = (m_run[i] == SC);
      m_qval[i] = di;
      m_en_prev[i] = en[i];
      m_d_prev[i] = di;
    end
  endtask

  task automatic cmp(input string name, input logic v, input logic [DW-1:0] d,
                     input logic [1:0] c, input logic [NC-1:0] o);
    n_vec++;
    if (dout_valid !== v || dataout !== d || dout_ch !== c || ovf !== o) begin
      n_err++;
      $display("FAIL %s @%0t: got valid=%b data=%h ch=%0d ovf=%b, want valid=%b data=%h ch=%0d ovf=%b",
               name, $time, dout_valid, dataout, dout_ch, ovf, v, d, c, o);
    end
  endtask

  task automatic do_reset();
    data_en = '0; data_in = '0; dout_ready = 1'b0;
    arstn = 1'b0;
    repeat (2) @(posedge clk_a);
    @(negedge clk_a);
    arstn = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic [NC-1:0] en, input logic [NC*DW-1:0] d,
                      input logic rdy);
    data_en = en; data_in = d; dout_ready = rdy;
    @(posedge clk_a);
    model_edge(en, d, rdy);
    #1;
    cmp("model", m_valid, m_data, m_ch, m_ovf);
  endtask

  typedef struct packed {
    logic          rst;
    logic [NC-1:0] en;
    logic [NC*DW-1:0] data;
    logic          rdy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_ch;
    logic [NC-1:0] exp_ovf;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input int n, input logic rst, input logic [NC-1:0] en,
                     input logic [NC*DW-1:0] d, input logic rdy, input logic ev,
                     input logic [DW-1:0] ed, input logic [1:0] ec,
                     input logic [NC-1:0] eo);
    vec_t r;
    for (int k = 0; k < n; k++) begin
      r = '{rst: rst && (k == 0), en: en, data: d, rdy: rdy, exp_valid: ev,
            exp_data: ed, exp_ch: ec, exp_ovf: eo};
      tbl.push_back(r);
    end
  endtask

  logic [NC-1:0]    r_en;
  logic [NC*DW-1:0] r_d;

  initial begin
    arstn = 1'b0;
    data_en = '0; data_in = '0; dout_ready = 1'b0;
    #2;
    cmp("reset_state", 1'b0, '0, '0, '0);

    // Single channel: ch1=A, valid for exactly one cycle after edge 5.
    add(1, 1, 4'b0010, 16'h00A0, 1, 0, 4'h0, 0, 4'b0000);
    add(4, 0, 4'b0010, 16'h00A0, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0010, 16'h00A0, 1, 1, 4'hA, 1, 4'b0000);
    add(2, 0, 4'b0010, 16'h00A0, 1, 0, 4'hA, 1, 4'b0000);
    add(2, 0, 4'b0000, 16'h0000, 1, 0, 4'hA, 1, 4'b0000);
    // Instability: 3,3,5,5,5,5 delivers only 5.
    add(1, 1, 4'b0001, 16'h0003, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0001, 16'h0003, 1, 0, 4'h0, 0, 4'b0000);
    add(4, 0, 4'b0001, 16'h0005, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 1, 4'h5, 0, 4'b0000);
    add(2, 0, 4'b0000, 16'h0000, 1, 0, 4'h5, 0, 4'b0000);
    // Contention: ch0=1, ch2=2, ch3=3 together (same order in both modes from reset).
    add(1, 1, 4'b1101, 16'h3201, 1, 0, 4'h0, 0, 4'b0000);
    add(3, 0, 4'b1101, 16'h3201, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 1, 4'h1, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 1, 4'h2, 2, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 1, 4'h3, 3, 4'b0000);
    add(1, 0, 4'b0000, 16'h0000, 1, 0, 4'h3, 3, 4'b0000);
    // Backpressure: ch0 holds the output, ch1 qualifies 6 then 9 -> ovf[1].
    add(1, 1, 4'b0001, 16'h0067, 0, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0001, 16'h0067, 0, 0, 4'h0, 0, 4'b0000);
    add(2, 0, 4'b0011, 16'h0067, 0, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0010, 16'h0067, 0, 0, 4'h0, 0, 4'b0000);
    add(1, 0, 4'b0010, 16'h0067, 0, 1, 4'h7, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0067, 0, 1, 4'h7, 0, 4'b0000);
    add(4, 0, 4'b0010, 16'h0097, 0, 1, 4'h7, 0, 4'b0000);
    add(1, 0, 4'b0000, 16'h0097, 0, 1, 4'h7, 0, 4'b0010);
    add(1, 0, 4'b0000, 16'h0097, 1, 1, 4'h9, 1, 4'b0010);
    add(2, 0, 4'b0000, 16'h0097, 1, 0, 4'h9, 1, 4'b0010);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].en, tbl[i].data, tbl[i].rdy);
      cmp($sformatf("tbl[%0d]", i), tbl[i].exp_valid, tbl[i].exp_data,
          tbl[i].exp_ch, tbl[i].exp_ovf);
    end

    // Async reset with output busy, ch3 pending and ovf[1] still set.
    repeat (6) step(4'b1100, 16'h5400, 1'b0);
    cmp("pre_reset_busy", 1'b1, 4'h4, 2'd2, 4'b0010);
    #2;
    arstn = 1'b0;
    data_en = '0; data_in = '0;
    #1;
    cmp("reset_async", 1'b0, '0, '0, '0);
    model_reset();
    @(negedge clk_a);
    arstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(4'b0000, 16'h0000, 1'b1);
      cmp("no_stale", 1'b0, '0, '0, '0);
    end

    // Random phase.
    do_reset();
    r_en = '0; r_d = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 7) == 0) r_en[i] = ~r_en[i];
        if ($urandom_range(0, 5) == 0) r_d[i*DW +: DW] = DW'($urandom_range(0, 15));
      end
      step(r_en, r_d, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
